microsequencer_param: RTL and testbench
=======================================

MICROSEQUENCER_PARAM -- requirements
Module: microsequencer_param

Interface
- REQ-001 Parameters SHALL be:
  - UPC_W, default 4: µPC width.
  - STACK_DEPTH, default 2: µ-return stack entries (≥1).
  - FETCH_LEN, default 2: µPC values below this are fetch states.
- REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
- REQ-003 Ports SHALL be:
  - clk4      in   1            clock, rising edge
  - reset     in   1            sync reset, active-high
  - nrsthold  in   1            reset-hold, active-low
  - nhalt     in   1            halt, active-low
  - nws       in   1            wait state, active-low
  - nend      in   1            microword end, active-low
  - nendext   in   1            external end, active-low
  - uop       in   2            00 NEXT, 01 JUMP, 10 CALL, 11 RET
  - utarget   in   UPC_W        JUMP/CALL target
  - upc       out  UPC_W        current µPC, registered
  - ncse      out  1            microcode store enable, active-low
  - fpfetch   out  1            fetch-state flag for DFP/front panel
  - sdepth    out  clog2(STACK_DEPTH+1)   stack occupancy
  - uerr      out  1            sticky stack over/underflow flag

Function
- REQ-004 ncse SHALL be combinational: reset OR NOT nhalt.
- REQ-005 fpfetch SHALL be combinational: (upc < FETCH_LEN).
- REQ-006 Per rising clk4 edge, the first matching priority SHALL apply:
  1. reset
  2. nrsthold low
  3. nhalt low or nws low
  4. nend low or nendext low
  5. uop
- REQ-007 With nrsthold low, upc SHALL become 0 and the stack SHALL empty; uerr SHALL be unchanged.
- REQ-008 With nhalt or nws low, upc, stack and uerr SHALL hold, and nend, nendext and uop SHALL be ignored.
- REQ-009 With nend or nendext low, upc SHALL become 0, the stack SHALL empty, and uop SHALL be ignored.
- REQ-010 NEXT SHALL set upc to upc+1 modulo 2^UPC_W (all-ones wraps to 0, no flag).
- REQ-011 JUMP SHALL set upc to utarget; the stack SHALL be unchanged.
- REQ-012 CALL with sdepth < STACK_DEPTH SHALL push (upc+1) mod 2^UPC_W, set upc to utarget and increment sdepth.
- REQ-013 CALL with the stack full SHALL set uerr, set upc to 0 and empty the stack (forced end).
- REQ-014 RET with sdepth > 0 SHALL pop the top entry into upc and decrement sdepth.
- REQ-015 RET with the stack empty SHALL set uerr and set upc to 0.
- REQ-016 The stack SHALL be LIFO; a push and a pop never occur in the same cycle.
- REQ-017 Every state change SHALL take effect one edge after its sampled inputs; there SHALL be no combinational path from uop or utarget to upc.
- REQ-018 uerr SHALL be cleared only by reset.

Reset
- REQ-019 Reset SHALL set upc=0, sdepth=0 and uerr=0, giving ncse=1 and fpfetch=1 (for FETCH_LEN ≥ 1).
- REQ-020 Reset asserted mid-CALL/RET or during halt SHALL override all other inputs on that edge.
- REQ-021 Stack entry contents need no reset; only sdepth is architecturally visible.

Structure
- REQ-022 The uop encodings (NEXT/JUMP/CALL/RET) SHALL live in a shared sequencer constants include, reused by the microcode assembler tables.
- REQ-023 The return stack SHALL be one sub-module, ustack (parameters: depth and width; push/pop/clear/full/empty).
- REQ-024 Address assembly and the microcode store SHALL stay outside this block.

Verification
- REQ-025 The bench SHALL cover these directed scenarios (defaults UPC_W=4, STACK_DEPTH=2):
  - Reset, then 16 NEXT cycles with all enables high -> upc steps 0..15, then wraps to 0; uerr=0.
  - At upc=3, CALL target 9 -> upc=9, sdepth=1; then NEXT, then RET -> upc=4, sdepth=0.
  - Two nested CALLs, then a third CALL at upc=5 -> uerr=1, upc=0, sdepth=0.
  - RET with empty stack -> uerr=1, upc=0; uerr stays 1 until reset.
  - nws low for 3 cycles while uop=JUMP 7 at upc=2 -> upc stays 2; after nws releases, upc=7.
  - nend low with uop=CALL at sdepth=1 -> upc=0, sdepth=0.
  - nrsthold low alongside nhalt low -> upc=0.
  - Reset during halt -> upc=0, uerr=0.

Source files
------------

// File: rtl/microsequencer_param_pkg.sv
// Shared sequencer constants: micro-op encodings (reused by the microcode
// assembler tables) and the internal per-edge action code.
package microsequencer_param_pkg;

  localparam int UOP_W = 2;

  // Micro-op field encodings as they appear in the microword.
  typedef enum logic [UOP_W-1:0] {
    UOP_NEXT = 2'b00,
    UOP_JUMP = 2'b01,
    UOP_CALL = 2'b10,
    UOP_RET  = 2'b11
  } uop_e;

  // What the sequencer does on the coming edge, after priority resolution.
  typedef enum logic [2:0] {
    ACT_HOLD      = 3'd0,  // halt / wait state: nothing moves
    ACT_CLEAR     = 3'd1,  // reset-hold or microword end: upc=0, stack empty
    ACT_NEXT      = 3'd2,
    ACT_JUMP      = 3'd3,
    ACT_CALL      = 3'd4,
    ACT_RET       = 3'd5,
    ACT_ERR_CLEAR = 3'd6,  // CALL into a full stack: forced end plus uerr
    ACT_ERR_ZERO  = 3'd7   // RET from an empty stack: upc=0 plus uerr
  } seq_act_e;

endpackage

// File: rtl/microsequencer_param_if.sv
// Connection between the sequencer core and its return stack.
// Handshake: push, pop and clear are single-cycle strobes sampled on the
// rising clock edge; the stack accepts them unconditionally in that cycle.
// push and pop are never asserted together, and clear wins over both.
// full, empty, depth and top_data are valid combinationally every cycle and
// describe the stack contents before the edge.
interface microsequencer_param_if #(
  parameter int WIDTH   = 4,
  parameter int DEPTH_W = 2
);
  logic               push;
  logic               pop;
  logic               clear;
  logic [WIDTH-1:0]   push_data;
  logic [WIDTH-1:0]   top_data;
  logic               full;
  logic               empty;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output push, pop, clear, push_data,
    input  top_data, full, empty, depth
  );

  modport slave (
    input  push, pop, clear, push_data,
    output top_data, full, empty, depth
  );
endinterface

// File: rtl/microsequencer_param_ustack.sv
// LIFO micro-return stack. Only the occupancy count is reset; entry
// contents are don't-care until written.
module microsequencer_param_ustack #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  microsequencer_param_if.slave  stk
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic [WIDTH-1:0]   top_data;

  assign full    = (depth_q == DEPTH_W'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = stk.push && !full && !stk.clear;
  assign do_pop  = stk.pop && !empty && !stk.clear;

  // Occupancy counter; clear and reset both empty the stack.
  always_ff @(posedge clk_i) begin
    if (rst_i || stk.clear) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + 1'b1;
    end else if (do_pop) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (depth_q == DEPTH_W'(i))) begin
        mem_q[i] <= stk.push_data;
      end
    end
  end

  // Top-of-stack read mux; returns zero when empty.
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) begin
        top_data = mem_q[i];
      end
    end
  end

  assign stk.top_data = top_data;
  assign stk.full     = full;
  assign stk.empty    = empty;
  assign stk.depth    = depth_q;

endmodule

// File: rtl/microsequencer_param.sv
// Microsequencer: registered micro-PC with NEXT/JUMP/CALL/RET, halt and
// wait-state hold, microword-end restart and a small return stack.
module microsequencer_param
  import microsequencer_param_pkg::*;
#(
  parameter  int UPC_W       = 4,
  parameter  int STACK_DEPTH = 2,
  parameter  int FETCH_LEN   = 2,
  localparam int SD_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk4,
  input  logic             reset,
  input  logic             nrsthold,
  input  logic             nhalt,
  input  logic             nws,
  input  logic             nend,
  input  logic             nendext,
  input  logic [UOP_W-1:0] uop,
  input  logic [UPC_W-1:0] utarget,
  output logic [UPC_W-1:0] upc,
  output logic             ncse,
  output logic             fpfetch,
  output logic [SD_W-1:0]  sdepth,
  output logic             uerr
);

  logic [UPC_W-1:0] upc_q, upc_d;
  logic             uerr_q, uerr_d;
  logic [UPC_W-1:0] upc_inc;
  seq_act_e         act;

  microsequencer_param_if #(.WIDTH(UPC_W), .DEPTH_W(SD_W)) stk_if ();

  microsequencer_param_ustack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (UPC_W)
  ) u_ustack (
    .clk_i (clk4),
    .rst_i (reset),
    .stk   (stk_if)
  );

  // Wraps modulo 2^UPC_W naturally through the register width.
  assign upc_inc = upc_q + 1'b1;

  // Resolve input priority into a single action for this edge.
  always_comb begin
    act = ACT_HOLD;
    if (!nrsthold) begin
      act = ACT_CLEAR;
    end else if (!nhalt || !nws) begin
      act = ACT_HOLD;
    end else if (!nend || !nendext) begin
      act = ACT_CLEAR;
    end else begin
      case (uop_e'(uop))
        UOP_NEXT: act = ACT_NEXT;
        UOP_JUMP: act = ACT_JUMP;
        UOP_CALL: act = stk_if.full  ? ACT_ERR_CLEAR : ACT_CALL;
        UOP_RET:  act = stk_if.empty ? ACT_ERR_ZERO  : ACT_RET;
        default:  act = ACT_HOLD;
      endcase
    end
  end

  // Next micro-PC, error flag and stack strobes for the chosen action.
  always_comb begin
    upc_d            = upc_q;
    uerr_d           = uerr_q;
    stk_if.push      = 1'b0;
    stk_if.pop       = 1'b0;
    stk_if.clear     = 1'b0;
    stk_if.push_data = upc_inc;
    case (act)
      ACT_HOLD: begin
        upc_d = upc_q;
      end
      ACT_CLEAR: begin
        upc_d        = '0;
        stk_if.clear = 1'b1;
      end
      ACT_NEXT: begin
        upc_d = upc_inc;
      end
      ACT_JUMP: begin
        upc_d = utarget;
      end
      ACT_CALL: begin
        upc_d       = utarget;
        stk_if.push = 1'b1;
      end
      ACT_RET: begin
        upc_d      = stk_if.top_data;
        stk_if.pop = 1'b1;
      end
      ACT_ERR_CLEAR: begin
        upc_d        = '0;
        uerr_d       = 1'b1;
        stk_if.clear = 1'b1;
      end
      ACT_ERR_ZERO: begin
        upc_d  = '0;
        uerr_d = 1'b1;
      end
      default: begin
        upc_d = upc_q;
      end
    endcase
  end

  // State registers; reset overrides every other input on the edge.
  always_ff @(posedge clk4) begin
    if (reset) begin
      upc_q  <= '0;
      uerr_q <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      uerr_q <= uerr_d;
    end
  end

  assign upc     = upc_q;
  assign uerr    = uerr_q;
  assign sdepth  = stk_if.depth;
  assign ncse    = reset | ~nhalt;
  assign fpfetch = (int'(upc_q) < FETCH_LEN);

endmodule

// File: tb/tb_microsequencer_param.sv
// Bench for microsequencer_param: directed table, wrap sequence and
// randomized run against a queue-based reference model.
module tb_microsequencer_param;
  localparam int UPC_W = 4;
  localparam int DEPTH = 2;
  localparam int FLEN  = 2;
  localparam int MODV  = 1 << UPC_W;

  logic             clk4 = 1'b0;
  logic             reset, nrsthold, nhalt, nws, nend, nendext;
  logic [1:0]       uop;
  logic [UPC_W-1:0] utarget;
  logic [UPC_W-1:0] upc;
  logic             ncse, fpfetch, uerr;
  logic [1:0]       sdepth;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int       m_upc;
  int       m_err;
  int       m_stk[$];

  microsequencer_param #(.UPC_W(UPC_W), .STACK_DEPTH(DEPTH), .FETCH_LEN(FLEN)) dut (
    .clk4     (clk4),
    .reset    (reset),
    .nrsthold (nrsthold),
    .nhalt    (nhalt),
    .nws      (nws),
    .nend     (nend),
    .nendext  (nendext),
    .uop      (uop),
    .utarget  (utarget),
    .upc      (upc),
    .ncse     (ncse),
    .fpfetch  (fpfetch),
    .sdepth   (sdepth),
    .uerr     (uerr)
  );

  always #5 clk4 = ~clk4;

  typedef struct {
    logic       rst, hold_n, halt_n, ws_n, end_n, endx_n;
    logic [1:0] op;
    int         tgt;
    int         e_upc, e_depth, e_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one set of inputs, clock once, and return #1 after the edge.
  task automatic step(input logic r, input logic h, input logic hl, input logic w,
                      input logic e, input logic ex, input logic [1:0] op, input int tgt);
    reset = r; nrsthold = h; nhalt = hl; nws = w; nend = e; nendext = ex;
    uop = op; utarget = UPC_W'(tgt);
    @(posedge clk4);
    #1;
  endtask

  // Behavioural reference: one edge of the sequencer rules.
  task automatic model_edge(input logic r, input logic h, input logic hl, input logic w,
                            input logic e, input logic ex, input logic [1:0] op, input int tgt);
    if (r) begin
      m_upc = 0; m_err = 0; m_stk.delete();
    end else if (!h) begin
      m_upc = 0; m_stk.delete();
    end else if (!hl || !w) begin
      m_upc = m_upc;
    end else if (!e || !ex) begin
      m_upc = 0; m_stk.delete();
    end else begin
      case (op)
        2'b00: m_upc = (m_upc + 1) % MODV;
        2'b01: m_upc = tgt;
        2'b10: begin
          if (m_stk.size() == DEPTH) begin
            m_err = 1; m_upc = 0; m_stk.delete();
          end else begin
            m_stk.push_back((m_upc + 1) % MODV);
            m_upc = tgt;
          end
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_err = 1; m_upc = 0;
          end else begin
            m_upc = m_stk.pop_back();
          end
        end
      endcase
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic h, input logic hl, input logic w,
                              input logic e, input logic ex, input logic [1:0] op, input int tgt,
                              input int eu, input int ed, input int ee);
    vec_t v;
    v.rst = r; v.hold_n = h; v.halt_n = hl; v.ws_n = w; v.end_n = e; v.endx_n = ex;
    v.op = op; v.tgt = tgt; v.e_upc = eu; v.e_depth = ed; v.e_err = ee;
    return v;
  endfunction

  initial begin
    reset = 1'b1; nrsthold = 1'b1; nhalt = 1'b1; nws = 1'b1;
    nend = 1'b1; nendext = 1'b1; uop = 2'b00; utarget = '0;

    // Reset then 16 NEXT cycles: 1..15 then wrap to 0.
    step(1, 1, 1, 1, 1, 1, 2'b00, 0);
    check("reset_upc", int'(upc), 0);
    check("reset_depth", int'(sdepth), 0);
    check("reset_uerr", int'(uerr), 0);
    check("reset_ncse", int'(ncse), 1);
    check("reset_fpfetch", int'(fpfetch), 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 1, 1, 1, 1, 2'b00, 0);
      check("wrap_upc", int'(upc), i % 16);
      check("wrap_fpfetch", int'(fpfetch), ((i % 16) < FLEN) ? 1 : 0);
    end
    check("wrap_uerr", int'(uerr), 0);
    check("run_ncse", int'(ncse), 0);

    // Directed table: r, hold_n, halt_n, ws_n, end_n, endx_n, op, tgt -> upc, depth, uerr.
    vecs.push_back(mk(1,1,1,1,1,1,2'b00, 0,  0,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  1,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  2,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  3,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 9,  9,1,0));  // CALL 9 at 3
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0, 10,1,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b11, 0,  4,0,0));  // RET -> 4
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 8,  8,1,0));  // nested CALL, push 5
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 5,  5,2,0));  // push 9
    vecs.push_back(mk(0,1,1,1,1,1,2'b10,10,  0,0,1));  // third CALL: overflow
    vecs.push_back(mk(1,1,1,1,1,1,2'b00, 0,  0,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b11, 0,  0,0,1));  // RET empty
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  1,0,1));
    vecs.push_back(mk(0,0,1,1,1,1,2'b00, 0,  0,0,1));  // rsthold keeps uerr
    vecs.push_back(mk(0,1,1,1,0,1,2'b00, 0,  0,0,1));
    vecs.push_back(mk(1,1,1,1,1,1,2'b00, 0,  0,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b01, 2,  2,0,0));
    vecs.push_back(mk(0,1,1,0,1,1,2'b01, 7,  2,0,0));  // nws low x3
    vecs.push_back(mk(0,1,1,0,1,1,2'b01, 7,  2,0,0));
    vecs.push_back(mk(0,1,1,0,1,1,2'b01, 7,  2,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b01, 7,  7,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 3,  3,1,0));
    vecs.push_back(mk(0,1,1,1,0,1,2'b10, 6,  0,0,0));  // nend beats CALL
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  1,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 4,  4,1,0));
    vecs.push_back(mk(0,0,0,1,1,1,2'b00, 0,  0,0,0));  // rsthold beats halt
    vecs.push_back(mk(0,1,1,1,1,1,2'b11, 0,  0,0,1));
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  1,0,1));
    vecs.push_back(mk(0,1,0,1,1,1,2'b00, 0,  1,0,1));  // halt holds
    vecs.push_back(mk(1,1,0,1,1,1,2'b10, 9,  0,0,0));  // reset during halt
    vecs.push_back(mk(0,1,1,1,1,1,2'b00, 0,  1,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,2'b01, 5,  0,0,0));  // nendext
    vecs.push_back(mk(0,1,1,1,1,1,2'b01,15, 15,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,2'b10, 6,  6,1,0));  // pushes 0 (wrapped)
    vecs.push_back(mk(0,1,1,1,1,1,2'b11, 0,  0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      step(v.rst, v.hold_n, v.halt_n, v.ws_n, v.end_n, v.endx_n, v.op, v.tgt);
      check($sformatf("vec%0d_upc", i), int'(upc), v.e_upc);
      check($sformatf("vec%0d_depth", i), int'(sdepth), v.e_depth);
      check($sformatf("vec%0d_uerr", i), int'(uerr), v.e_err);
      check($sformatf("vec%0d_ncse", i), int'(ncse), (v.rst || !v.halt_n) ? 1 : 0);
      check($sformatf("vec%0d_fpfetch", i), int'(fpfetch), (v.e_upc < FLEN) ? 1 : 0);
    end

    // Randomized run against the reference model.
    m_upc = 0; m_err = 0; m_stk.delete();
    step(1, 1, 1, 1, 1, 1, 2'b00, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, h, hl, w, e, ex;
      logic [1:0] op;
      int tgt;
      r   = ($urandom_range(0, 49) == 0);
      h   = ($urandom_range(0, 24) != 0);
      hl  = ($urandom_range(0, 7) != 0);
      w   = ($urandom_range(0, 7) != 0);
      e   = ($urandom_range(0, 11) != 0);
      ex  = ($urandom_range(0, 11) != 0);
      op  = 2'($urandom_range(0, 3));
      tgt = $urandom_range(0, MODV - 1);
      model_edge(r, h, hl, w, e, ex, op, tgt);
      step(r, h, hl, w, e, ex, op, tgt);
      check("rnd_upc", int'(upc), m_upc);
      check("rnd_depth", int'(sdepth), m_stk.size());
      check("rnd_uerr", int'(uerr), m_err);
      check("rnd_ncse", int'(ncse), (r || !hl) ? 1 : 0);
      check("rnd_fpfetch", int'(fpfetch), (m_upc < FLEN) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
